// File: rtl/sparce_pkg.sv
// Shared types, field positions and default addresses for the sparsity skip unit.
// The skip table (SASA) entry format is decoded here so the top and the bench agree on it.
package sparce_pkg;

  localparam logic [31:0] DEFAULT_SASA_ADDR_BASE = 32'h9000_1000;
  localparam logic [31:0] DEFAULT_SASA_CTRL_ADDR = 32'h9000_1004;

  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 16;
  localparam int RS1_MSB  = 15;
  localparam int RS1_LSB  = 11;
  localparam int RS2_MSB  = 10;
  localparam int RS2_LSB  = 6;
  localparam int COND_BIT = 5;
  localparam int CNT_MSB  = 4;
  localparam int CNT_LSB  = 0;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  typedef enum logic {
    SASA_OR  = 1'b0,
    SASA_AND = 1'b1
  } sasa_cond_t;

  typedef struct packed {
    logic       valid;
    logic [15:0] pc_tag;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    sasa_cond_t  cond;
    logic [4:0]  skip_cnt;
  } sasa_entry_t;

  function automatic sasa_entry_t decode_entry(input logic [31:0] data);
    sasa_entry_t e;
    e.valid    = 1'b1;
    e.pc_tag   = data[TAG_MSB:TAG_LSB];
    e.rs1      = data[RS1_MSB:RS1_LSB];
    e.rs2      = data[RS2_MSB:RS2_LSB];
    e.cond     = sasa_cond_t'(data[COND_BIT]);
    e.skip_cnt = data[CNT_MSB:CNT_LSB];
    return e;
  endfunction

endpackage

// File: rtl/sparce_sprf.sv
// Sparsity register file: one "is zero" bit per architectural register.
// A writeback in the same cycle is bypassed onto the read ports so lookups see fresh values.
module sparce_sprf (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        zero1,
  output logic        zero2
);

  logic [31:0] zero_mask_q;
  logic [31:0] zero_mask_d;
  logic        wb_live;
  logic        wb_zero;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wb_live     = wb_en && (rd != 5'd0);
    wb_zero     = (wb_data == 32'd0);
    zero_mask_d = zero_mask_q;
    if (wb_live) begin
      zero_mask_d[rd] = wb_zero;
    end
    zero_mask_d[0] = 1'b1;

    zero1 = (wb_live && (rd == rs1)) ? wb_zero : zero_mask_q[rs1];
    zero2 = (wb_live && (rd == rs2)) ? wb_zero : zero_mask_q[rs2];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      zero_mask_q <= 32'h0000_0001;
    end else begin
      zero_mask_q <= zero_mask_d;
    end
  end

endmodule

// File: rtl/sparce_skip_unit.sv
// Skip unit top: SASA table, control register, priority PC matcher and redirect outputs.
// A fire at cycle N drives skipping for N+1 only and blocks the wrong-path lookup in N+1.
module sparce_skip_unit
  import sparce_pkg::*;
#(
  parameter int          SASA_ENTRIES   = 8,
  parameter logic [31:0] SASA_ADDR_BASE = DEFAULT_SASA_ADDR_BASE,
  parameter logic [31:0] SASA_CTRL_ADDR = DEFAULT_SASA_CTRL_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        if_ex_enable,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic        skipping,
  output logic [31:0] sparce_target
);

  localparam int PTR_W = $clog2(SASA_ENTRIES);

  sasa_entry_t       entries_q [SASA_ENTRIES];
  sasa_entry_t       entries_d [SASA_ENTRIES];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              enable_q, enable_d;
  logic              cooldown_q, cooldown_d;
  logic              skipping_q, skipping_d;
  logic [31:0]       target_q, target_d;

  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              lookup_en;
  logic              zero1, zero2;
  logic              cond_met;
  logic              fire;
  logic              ctrl_wr;
  logic              entry_wr;

  sparce_sprf u_sprf (
    .CLK     (CLK),
    .RST     (RST),
    .wb_en   (wb_en),
    .rd      (rd),
    .wb_data (wb_data),
    .rs1     (entries_q[hit_idx].rs1),
    .rs2     (entries_q[hit_idx].rs2),
    .zero1   (zero1),
    .zero2   (zero2)
  );

  // Priority match: scan high to low so the lowest matching index is the last one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (entries_q[i].valid && (entries_q[i].pc_tag == pc[17:2])) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    lookup_en = enable_q && if_ex_enable && !cooldown_q;
    cond_met  = (entries_q[hit_idx].cond == SASA_AND) ? (zero1 && zero2) : (zero1 || zero2);
    fire      = lookup_en && hit && cond_met;

    skipping_d = fire;
    cooldown_d = fire;
    target_d   = target_q;
    if (fire) begin
      target_d = pc + ((32'(entries_q[hit_idx].skip_cnt) + 32'd1) << 2);
    end
  end

  // Table and control writes; lookup above always reads the pre-write contents.
  always_comb begin
    ctrl_wr   = sasa_wen && (sasa_addr == SASA_CTRL_ADDR);
    entry_wr  = sasa_wen && (sasa_addr == SASA_ADDR_BASE) && (sasa_data[CNT_MSB:CNT_LSB] != 5'd0);
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    enable_d  = enable_q;

    if (entry_wr) begin
      entries_d[wr_ptr_q] = decode_entry(sasa_data);
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (ctrl_wr) begin
      enable_d = sasa_data[CTRL_ENABLE_BIT];
      if (sasa_data[CTRL_FLUSH_BIT]) begin
        for (int i = 0; i < SASA_ENTRIES; i++) begin
          entries_d[i].valid = 1'b0;
        end
        wr_ptr_d = '0;
      end
    end
  end

  // NOTE: only the valid bits of the table are reset; payload fields are don't-care while invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
      wr_ptr_q   <= '0;
      enable_q   <= 1'b0;
      cooldown_q <= 1'b0;
      skipping_q <= 1'b0;
      target_q   <= 32'd0;
    end else begin
      entries_q  <= entries_d;
      wr_ptr_q   <= wr_ptr_d;
      enable_q   <= enable_d;
      cooldown_q <= cooldown_d;
      skipping_q <= skipping_d;
      target_q   <= target_d;
    end
  end

  assign skipping      = skipping_q;
  assign sparce_target = target_q;

endmodule

// File: tb/tb_sparce_skip_unit.sv
// Self-checking bench for sparce_skip_unit: directed scenarios then random traffic,
// all compared every cycle against a register-value / write-log reference model.
module tb_sparce_skip_unit;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h9000_1000;
  localparam logic [31:0] CTRL = 32'h9000_1004;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc;
  logic        if_ex_enable;
  logic        wb_en;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        skipping;
  logic [31:0] sparce_target;

  always #5 CLK = ~CLK;

  sparce_skip_unit #(
    .SASA_ENTRIES   (N),
    .SASA_ADDR_BASE (BASE),
    .SASA_CTRL_ADDR (CTRL)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .pc            (pc),
    .if_ex_enable  (if_ex_enable),
    .wb_en         (wb_en),
    .rd            (rd),
    .wb_data       (wb_data),
    .sasa_wen      (sasa_wen),
    .sasa_addr     (sasa_addr),
    .sasa_data     (sasa_data),
    .skipping      (skipping),
    .sparce_target (sparce_target)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: register values, a log of live table writes, control state.
  typedef struct {
    logic [15:0] tag;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          is_and;
    int          cnt;
  } m_ent_t;

  m_ent_t      m_log[$];
  int          m_wcount;
  bit          m_enable;
  bit          m_cool;
  bit          m_skip;
  logic [31:0] m_target;
  logic [31:0] m_regs [32];

  task automatic m_reset();
    m_log.delete();
    m_wcount = 0;
    m_enable = 0;
    m_cool   = 0;
    m_skip   = 0;
    m_target = 32'd0;
    m_regs[0] = 32'd0;
    for (int r = 1; r < 32; r++) m_regs[r] = 32'd1;
  endtask

  function automatic bit m_zero(input logic [4:0] r);
    if (r == 5'd0) return 1'b1;
    if (wb_en && (rd == r)) return (wb_data == 32'd0);
    return (m_regs[r] == 32'd0);
  endfunction

  task automatic step(input string tag);
    bit     fire;
    int     best_slot;
    m_ent_t best;
    m_ent_t e;
    fire      = 0;
    best_slot = N;
    if (m_enable && if_ex_enable && !m_cool) begin
      for (int j = 0; j < m_log.size(); j++) begin
        int slot;
        slot = (m_wcount - m_log.size() + j) % N;
        if ((m_log[j].tag == pc[17:2]) && (slot < best_slot)) begin
          best_slot = slot;
          best      = m_log[j];
        end
      end
      if (best_slot < N) begin
        fire = best.is_and ? (m_zero(best.rs1) && m_zero(best.rs2))
                           : (m_zero(best.rs1) || m_zero(best.rs2));
      end
    end
    if (RST) begin
      m_reset();
    end else begin
      m_skip = fire;
      m_cool = fire;
      if (fire) m_target = pc + 32'(4 * (best.cnt + 1));
      if (wb_en && (rd != 5'd0)) m_regs[rd] = wb_data;
      if (sasa_wen && (sasa_addr == CTRL)) begin
        m_enable = sasa_data[0];
        if (sasa_data[1]) begin
          m_log.delete();
          m_wcount = 0;
        end
      end else if (sasa_wen && (sasa_addr == BASE) && (sasa_data[4:0] != 5'd0)) begin
        e.tag    = sasa_data[31:16];
        e.rs1    = sasa_data[15:11];
        e.rs2    = sasa_data[10:6];
        e.is_and = sasa_data[5];
        e.cnt    = int'(sasa_data[4:0]);
        m_log.push_back(e);
        m_wcount++;
        if (m_log.size() > N) void'(m_log.pop_front());
      end
    end
    @(posedge CLK);
    #1;
    check({tag, ".skipping"}, 32'(skipping), 32'(m_skip));
    check({tag, ".target"}, sparce_target, m_target);
  endtask

  task automatic idle();
    if_ex_enable = 1'b0;
    wb_en        = 1'b0;
    rd           = 5'd0;
    wb_data      = 32'd0;
    sasa_wen     = 1'b0;
    sasa_addr    = 32'd0;
    sasa_data    = 32'd0;
  endtask

  task automatic wr_entry(input string tag, input logic [31:0] tpc, input logic [4:0] r1,
                          input logic [4:0] r2, input bit is_and, input logic [4:0] cnt);
    sasa_wen  = 1'b1;
    sasa_addr = BASE;
    sasa_data = {tpc[17:2], r1, r2, is_and, cnt};
    step(tag);
    sasa_wen  = 1'b0;
  endtask

  task automatic ctrl(input string tag, input logic [31:0] data);
    sasa_wen  = 1'b1;
    sasa_addr = CTRL;
    sasa_data = data;
    step(tag);
    sasa_wen  = 1'b0;
  endtask

  task automatic wb(input string tag, input logic [4:0] r, input logic [31:0] v);
    wb_en   = 1'b1;
    rd      = r;
    wb_data = v;
    step(tag);
    wb_en   = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] p);
    pc           = p;
    if_ex_enable = 1'b1;
    step(tag);
    if_ex_enable = 1'b0;
  endtask

  initial begin
    m_reset();
    idle();
    pc  = 32'd0;
    RST = 1'b1;
    step("rst0");
    step("rst1");
    RST = 1'b0;

    // 1: reset state, disabled lookup, zero_mask only marks x0.
    lookup("t1_lookup", 32'h100);
    check("t1_target_zero", sparce_target, 32'd0);
    ctrl("t1_en", 32'h3);
    wr_entry("t1_wr", 32'h100, 5'd5, 5'd6, 1'b0, 5'd1);
    lookup("t1_mask", 32'h100);

    // 2: OR entry with x0 fires, target = 0x100 + 4*4.
    ctrl("t2_flush", 32'h3);
    wr_entry("t2_wr", 32'h100, 5'd5, 5'd0, 1'b0, 5'd3);
    lookup("t2_fire", 32'h100);
    check("t2_target_const", sparce_target, 32'h110);
    check("t2_skip_const", 32'(skipping), 32'd1);
    step("t2_after");
    check("t2_drop_const", 32'(skipping), 32'd0);

    // 3: AND entry, then same-cycle bypass of a zero writeback.
    ctrl("t3_flush", 32'h3);
    wb("t3_x5", 5'd5, 32'd0);
    wb("t3_x6", 5'd6, 32'd7);
    wr_entry("t3_wr", 32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    lookup("t3_nofire", 32'h100);
    wb_en = 1'b1; rd = 5'd6; wb_data = 32'd0;
    lookup("t3_bypass", 32'h100);
    wb_en = 1'b0;
    step("t3_after");

    // 4: FIFO wrap, ignored zero-count write, unrelated address.
    ctrl("t4_flush", 32'h3);
    for (int k = 0; k < 9; k++) wr_entry("t4_wr", 32'h200 + 32'(4 * k), 5'd0, 5'd0, 1'b0, 5'(k + 1));
    lookup("t4_first_gone", 32'h200);
    lookup("t4_ninth", 32'h220);
    step("t4_gap");
    lookup("t4_second", 32'h204);
    step("t4_gap2");
    wr_entry("t4_cnt0", 32'h300, 5'd0, 5'd0, 1'b0, 5'd0);
    lookup("t4_cnt0_miss", 32'h300);
    sasa_wen = 1'b1; sasa_addr = BASE + 32'h8; sasa_data = 32'h3;
    step("t4_other_addr");
    sasa_wen = 1'b0;
    lookup("t4_still_live", 32'h208);
    step("t4_gap3");

    // 5: cooldown suppresses back-to-back match, clears after one cycle, flush kills hits.
    ctrl("t5_flush", 32'h3);
    wr_entry("t5_wr0", 32'h100, 5'd0, 5'd0, 1'b0, 5'd2);
    wr_entry("t5_wr1", 32'h104, 5'd0, 5'd0, 1'b0, 5'd5);
    lookup("t5_fire", 32'h100);
    lookup("t5_cooldown", 32'h104);
    lookup("t5_refire", 32'h104);
    step("t5_gap");
    ctrl("t5_flush2", 32'h3);
    lookup("t5_flushed", 32'h100);

    // Lowest index wins even when its condition fails; target wrap; enable=0.
    wb("p_x7", 5'd7, 32'd9);
    wr_entry("p_wr0", 32'h400, 5'd7, 5'd7, 1'b1, 5'd1);
    wr_entry("p_wr1", 32'h400, 5'd0, 5'd0, 1'b0, 5'd2);
    lookup("p_priority", 32'h400);
    wr_entry("p_wrap_wr", 32'hFFFF_FFF8, 5'd0, 5'd0, 1'b0, 5'd31);
    lookup("p_wrap", 32'hFFFF_FFF8);
    check("p_wrap_const", sparce_target, 32'h0000_0078);
    ctrl("p_dis", 32'h0);
    lookup("p_disabled", 32'hFFFF_FFF8);
    ctrl("p_en", 32'h1);
    lookup("p_reenabled", 32'hFFFF_FFF8);
    step("p_gap");

    // 6: reset during the skipping cycle.
    ctrl("t6_flush", 32'h3);
    wr_entry("t6_wr", 32'h100, 5'd0, 5'd0, 1'b0, 5'd3);
    lookup("t6_fire", 32'h100);
    RST = 1'b1;
    step("t6_rst");
    RST = 1'b0;
    ctrl("t6_en", 32'h1);
    lookup("t6_invalid", 32'h100);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      int sel;
      idle();
      RST          = ($urandom_range(0, 199) == 0);
      pc           = ($urandom & 32'hFFFC_0003) | (32'h100 + 32'(4 * $urandom_range(0, 3)));
      if_ex_enable = ($urandom_range(0, 3) != 0);
      wb_en        = $urandom_range(0, 1) == 1;
      rd           = 5'($urandom_range(0, 7));
      wb_data      = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      sel          = $urandom_range(0, 99);
      if (sel < 12) begin
        sasa_wen  = 1'b1;
        sasa_addr = BASE;
        sasa_data = {4'h0, 12'h040 + 12'($urandom_range(0, 3)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
      end else if (sel < 16) begin
        sasa_wen  = 1'b1;
        sasa_addr = CTRL;
        sasa_data = {30'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
      end else if (sel < 18) begin
        sasa_wen  = 1'b1;
        sasa_addr = BASE + 32'(4 * $urandom_range(2, 9));
        sasa_data = $urandom;
      end
      step("rand");
    end

    idle();
    RST = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
